// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the ThinPad SRAM arbiter: MEM-stage operation codes
//   (same encoding as controlMem), arbiter FSM state codes, owner codes and a
//   small helper that tells whether a MEM-stage op actually needs the SRAM.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // MEM-stage operation codes.
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] MEM_NONE  = 2'b11;

    // Arbiter FSM states. IDLE is encoded as zero so a cleared debug bus reads
    // as idle.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } arb_state_e;

    // Which pipeline stage currently owns the SRAM.
    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    // Only the read and write codes request the SRAM; anything else is idle.
    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_READ) || (op == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// -----------------------------------------------------------------------------
// sram_timer
//   Countdown used by the arbiter to time the oe_n / we_n strobe width.
//   'load' presets the counter to ACCESS_CYCLES-1; 'tick' decrements it;
//   'done' is high while the counter is zero, i.e. in the last strobe cycle.
//   The counter saturates at zero and never wraps.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous active-low reset (counter clears to 0)
//   load  in  preload ACCESS_CYCLES-1 (has priority over tick)
//   tick  in  decrement by one when non-zero
//   done  out counter is zero
// -----------------------------------------------------------------------------
module sram_timer #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam logic [3:0] LOAD_VAL = 4'(ACCESS_CYCLES - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (tick && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single ThinPad SRAM between the IF stage (instruction fetch,
//   read only) and the MEM stage (load/store). One requester is granted at a
//   time from IDLE with fixed priority (MEM beats IF, the older instruction
//   wins); the granted access is sequenced through the SRAM strobes and
//   finished with a one-cycle ack to its owner. The top level owns the
//   tri-state buffer; this block only says when ram_dout must be driven.
//
// Handshake: a requester holds its request (if_req=1 / mem_op!=11) and its
//   address/data stable until it sees its ack. The ack is a single-cycle
//   pulse; rdata is valid in that cycle and holds until the next capture.
//   A request dropped mid-access still completes and still gets its ack.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   if_req/if_addr            IF read request and word address
//   if_rdata/if_ack           instruction word and completion pulse
//   mem_op/mem_addr/mem_wdata MEM op (01 rd, 10 wr, 11 none), address, data
//   mem_rdata/mem_ack         load data and completion pulse
//   stall                     combinational pipeline freeze
//   ram_addr/ram_dout/ram_din SRAM address, write data, read data
//   ram_data_oe               1 = top drives ram_dout onto the SRAM bus
//   ram_en_n/ram_oe_n/ram_we_n SRAM strobes, active-low
//   state_dbg                 current FSM state (arb_state_e encoding)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    // IF port
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    // MEM port
    input  logic [1:0]  mem_op,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    // pipeline
    output logic        stall,
    // SRAM side
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    input  logic [15:0] ram_din,
    output logic        ram_data_oe,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    // debug
    output logic [2:0]  state_dbg
);

    arb_state_e  state_q,     state_d;
    owner_e      owner_q,     owner_d;
    logic        write_q,     write_d;
    logic [15:0] addr_q,      addr_d;
    logic [15:0] wdata_q,     wdata_d;
    logic [15:0] if_rdata_q,  if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q,    if_ack_d;
    logic        mem_ack_q,   mem_ack_d;
    logic        en_n_q,      en_n_d;
    logic        oe_n_q,      oe_n_d;
    logic        we_n_q,      we_n_d;
    logic        data_oe_q,   data_oe_d;

    logic        timer_load;
    logic        timer_tick;
    logic        timer_done;
    logic        mem_want;
    logic        if_want;

    sram_timer #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .tick (timer_tick),
        .done (timer_done)
    );

    // A requester is still holding its request during the cycle its ack is
    // high, so that request must not be granted a second time. The other
    // requester may be granted in that same cycle.
    assign mem_want = is_mem_access(mem_op) & ~mem_ack_q;
    assign if_want  = if_req & ~if_ack_q;

    // Next state, grant latching and ack generation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        timer_load  = 1'b0;
        timer_tick  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_want) begin
                    owner_d    = OWNER_MEM;
                    write_d    = (mem_op == MEM_WRITE);
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    timer_load = 1'b1;
                    state_d    = (mem_op == MEM_WRITE) ? ST_WR_SETUP : ST_RD;
                end else if (if_want) begin
                    owner_d    = OWNER_IF;
                    write_d    = 1'b0;
                    addr_d     = if_addr;
                    timer_load = 1'b1;
                    state_d    = ST_RD;
                end
            end

            ST_RD: begin
                timer_tick = 1'b1;
                if (timer_done) begin
                    // Last oe_n-low cycle: the SRAM data is settled.
                    if (owner_q == OWNER_MEM) begin
                        mem_rdata_d = ram_din;
                        mem_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d  = ram_din;
                        if_ack_d    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end

            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
            end

            ST_WR_PULSE: begin
                timer_tick = 1'b1;
                if (timer_done) begin
                    // Ack is raised for the hold cycle so the requester can
                    // release mem_op before the FSM is back in IDLE.
                    mem_ack_d = 1'b1;
                    state_d   = ST_WR_HOLD;
                end
            end

            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so the SRAM pins come
    // straight off flops and cannot glitch. ram_data_oe is only ever set in
    // write states, and oe_n is only low in RD, so they are exclusive.
    always_comb begin
        en_n_d    = (state_d == ST_IDLE);
        oe_n_d    = (state_d != ST_RD);
        we_n_d    = (state_d != ST_WR_PULSE);
        data_oe_d = (state_d == ST_WR_SETUP) ||
                    (state_d == ST_WR_PULSE) ||
                    (state_d == ST_WR_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IF;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            if_rdata_q  <= 16'h0000;
            mem_rdata_q <= 16'h0000;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            en_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            en_n_q      <= en_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            data_oe_q   <= data_oe_d;
        end
    end

    // write_q records the kind of the granted access; it is kept for
    // observability alongside the state and owner.
    logic unused_write;
    assign unused_write = write_q;

    assign if_rdata    = if_rdata_q;
    assign if_ack      = if_ack_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_ack     = mem_ack_q;
    assign ram_addr    = {2'b00, addr_q};
    assign ram_dout    = wdata_q;
    assign ram_data_oe = data_oe_q;
    assign ram_en_n    = en_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign state_dbg   = state_q;

    assign stall = (if_req & ~if_ack_q) | ((mem_op != MEM_NONE) & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter. A timeline model of one SRAM access (cycle index
//   since grant) predicts every output each cycle; directed transactions add
//   literal expectations for latency, strobe widths and data. A second
//   instance built with ACCESS_CYCLES=1 covers the short-timing build.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- main DUT (ACCESS_CYCLES=2) ----------------
    logic        if_req;
    logic [15:0] if_addr, if_rdata;
    logic        if_ack;
    logic [1:0]  mem_op;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, stall;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout, ram_din;
    logic        ram_data_oe, ram_en_n, ram_oe_n, ram_we_n;
    logic [2:0]  state_dbg;

    mem_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
        .ram_data_oe(ram_data_oe), .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .state_dbg(state_dbg)
    );

    // ---------------- second DUT (ACCESS_CYCLES=1) ----------------
    logic        if_req_1;
    logic [15:0] if_addr_1, if_rdata_1;
    logic        if_ack_1;
    logic [1:0]  mem_op_1;
    logic [15:0] mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        mem_ack_1, stall_1;
    logic [17:0] ram_addr_1;
    logic [15:0] ram_dout_1, ram_din_1;
    logic        ram_data_oe_1, ram_en_n_1, ram_oe_n_1, ram_we_n_1;
    logic [2:0]  state_dbg_1;

    mem_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ack(if_ack_1),
        .mem_op(mem_op_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .mem_ack(mem_ack_1), .stall(stall_1),
        .ram_addr(ram_addr_1), .ram_dout(ram_dout_1), .ram_din(ram_din_1),
        .ram_data_oe(ram_data_oe_1), .ram_en_n(ram_en_n_1), .ram_oe_n(ram_oe_n_1),
        .ram_we_n(ram_we_n_1), .state_dbg(state_dbg_1)
    );

    // ---------------- counters / check helper ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM models ----------------
    // Unwritten words read as addr ^ 16'h4A41 (so 0x0040 holds 0x4A01).
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h4A41;
    endfunction

    logic [15:0] sram [logic [15:0]];

    // Writes land while we_n is low; read data is presented for the cycle.
    always @(negedge clk) begin
        if (!ram_we_n && !ram_en_n) sram[ram_addr[15:0]] = ram_dout;
        if (ram_oe_n) ram_din = 16'h0000;
        else if (sram.exists(ram_addr[15:0])) ram_din = sram[ram_addr[15:0]];
        else ram_din = init_val(ram_addr[15:0]);
        ram_din_1 = ram_oe_n_1 ? 16'h0000 : (ram_addr_1[15:0] ^ 16'h1234);
    end

    // ---------------- behavioural model + compare ----------------
    logic [15:0] shadow [logic [15:0]];

    function automatic logic [15:0] shadow_rd(input logic [15:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    bit          m_busy, m_mem, m_write;
    int          m_t;
    logic [15:0] m_addr, m_wdata;
    logic        e_if_ack, e_mem_ack;
    logic [15:0] e_if_rdata, e_mem_rdata;
    logic        x_en_n, x_oe_n, x_we_n, x_doe, x_stall, n_if, n_mem, g_if, g_mem;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_mem = 0; m_write = 0; m_t = 0;
            m_addr = 16'h0; m_wdata = 16'h0;
            e_if_ack = 0; e_mem_ack = 0; e_if_rdata = 16'h0; e_mem_rdata = 16'h0;
        end else begin
            // expected outputs for this cycle
            x_en_n = 1; x_oe_n = 1; x_we_n = 1; x_doe = 0;
            if (m_busy) begin
                x_en_n = 0;
                if (!m_write) x_oe_n = 0;
                else begin
                    x_doe = 1;
                    if (m_t >= 2 && m_t <= AC + 1) x_we_n = 0;
                end
            end
            x_stall = (if_req & ~e_if_ack) | ((mem_op != 2'b11) & ~e_mem_ack);
            chk("en_n", 32'(ram_en_n), 32'(x_en_n));
            chk("oe_n", 32'(ram_oe_n), 32'(x_oe_n));
            chk("we_n", 32'(ram_we_n), 32'(x_we_n));
            chk("data_oe", 32'(ram_data_oe), 32'(x_doe));
            chk("ram_addr", 32'(ram_addr), 32'({2'b00, m_addr}));
            chk("ram_dout", 32'(ram_dout), 32'(m_wdata));
            chk("if_ack", 32'(if_ack), 32'(e_if_ack));
            chk("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
            chk("if_rdata", 32'(if_rdata), 32'(e_if_rdata));
            chk("mem_rdata", 32'(mem_rdata), 32'(e_mem_rdata));
            chk("stall", 32'(stall), 32'(x_stall));

            // advance one cycle using this cycle's (stable) inputs
            g_mem = ((mem_op == 2'b01) || (mem_op == 2'b10)) && !e_mem_ack;
            g_if  = if_req && !e_if_ack;
            n_if = 0; n_mem = 0;
            if (m_busy) begin
                if (!m_write && m_t == AC) begin
                    m_busy = 0;
                    if (m_mem) begin e_mem_rdata = shadow_rd(m_addr); n_mem = 1; end
                    else begin e_if_rdata = shadow_rd(m_addr); n_if = 1; end
                end else if (m_write && m_t == AC + 2) begin
                    m_busy = 0;
                    shadow[m_addr] = m_wdata;
                end else begin
                    m_t++;
                    if (m_write && m_t == AC + 2) n_mem = 1;
                end
            end else if (g_mem) begin
                m_busy = 1; m_t = 1; m_mem = 1; m_write = (mem_op == 2'b10);
                m_addr = mem_addr; m_wdata = mem_wdata;
            end else if (g_if) begin
                m_busy = 1; m_t = 1; m_mem = 0; m_write = 0; m_addr = if_addr;
            end
            e_if_ack = n_if; e_mem_ack = n_mem;
        end
    end

    // Drive enable and output enable must never overlap, in either build.
    always @(negedge clk) begin
        if (rst) begin
            chk("oe_mutex", 32'(ram_data_oe & ~ram_oe_n), 32'd0);
            chk("oe_mutex_ac1", 32'(ram_data_oe_1 & ~ram_oe_n_1), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // Each access starts in a fresh cycle; lat counts cycles from the request
    // cycle (0) to the ack cycle. stall_lo counts non-ack cycles with stall=0.
    task automatic if_access(input logic [15:0] a, output int lat, output int oe_lo,
                             output int stall_lo, output logic [15:0] rd);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        lat = 0; oe_lo = 0; stall_lo = 0;
        @(negedge clk);
        while (1) begin
            oe_lo += int'(!ram_oe_n);
            if (if_ack || lat >= 40) break;
            if (!stall) stall_lo++;
            @(negedge clk); lat++;
        end
        rd = if_rdata;
        chk("if_timeout", 32'(lat >= 40), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_access(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                              output int lat, output int we_lo, output int doe_hi,
                              output int stall_lo, output logic [15:0] rd);
        @(posedge clk); #1;
        mem_op = op; mem_addr = a; mem_wdata = d;
        lat = 0; we_lo = 0; doe_hi = 0; stall_lo = 0;
        @(negedge clk);
        while (1) begin
            we_lo  += int'(!ram_we_n);
            doe_hi += int'(ram_data_oe);
            if (mem_ack || lat >= 40) break;
            if (!stall) stall_lo++;
            @(negedge clk); lat++;
        end
        rd = mem_rdata;
        chk("mem_timeout", 32'(lat >= 40), 32'd0);
        @(posedge clk); #1;
        mem_op = 2'b11;
    endtask

    // ---------------- stimulus ----------------
    int          lat_a, lat_b, c1, c2, c3, c4, s_a, s_b, n;
    logic [15:0] rd_a, rd_b;

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = 0; mem_op = 2'b11; mem_addr = 0; mem_wdata = 0;
        if_req_1 = 0; if_addr_1 = 0; mem_op_1 = 2'b11; mem_addr_1 = 0; mem_wdata_1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_en_n", 32'(ram_en_n), 32'd1);
        chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rst_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_data_oe", 32'(ram_data_oe), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_rdata", 32'({if_rdata, mem_rdata}), 32'd0);

        // 1. IF read of 0x0040
        if_access(16'h0040, lat_a, c1, s_a, rd_a);
        chk("t1_lat", 32'(lat_a), 32'd3);
        chk("t1_oe_cycles", 32'(c1), 32'd2);
        chk("t1_rdata", 32'(rd_a), 32'h4A01);
        chk("t1_stall_lo", 32'(s_a), 32'd0);
        @(negedge clk);
        chk("t1_stall_after", 32'(stall), 32'd0);
        chk("t1_ram_addr", 32'(ram_addr), 32'h00040);

        // 2. MEM write 0xBEEF to 0x8000, then read it back
        mem_access(2'b10, 16'h8000, 16'hBEEF, lat_a, c1, c2, s_a, rd_a);
        chk("t2_lat", 32'(lat_a), 32'd4);
        chk("t2_we_cycles", 32'(c1), 32'd2);
        chk("t2_doe_cycles", 32'(c2), 32'd4);
        chk("t2_sram", 32'(sram.exists(16'h8000) ? sram[16'h8000] : 16'h0000), 32'hBEEF);
        mem_access(2'b01, 16'h8000, 16'h0000, lat_a, c1, c2, s_a, rd_a);
        chk("t2_readback", 32'(rd_a), 32'hBEEF);
        chk("t2_rd_lat", 32'(lat_a), 32'd3);

        // 3. contention: MEM read and IF read raised together
        fork
            mem_access(2'b01, 16'h0100, 16'h0000, lat_a, c1, c2, s_a, rd_a);
            if_access(16'h0200, lat_b, c3, s_b, rd_b);
        join
        chk("t3_mem_lat", 32'(lat_a), 32'd3);
        chk("t3_if_lat", 32'(lat_b), 32'd6);
        chk("t3_mem_rdata", 32'(rd_a), 32'h4B41);
        chk("t3_if_rdata", 32'(rd_b), 32'h4841);
        chk("t3_stall_lo", 32'(s_a + s_b), 32'd0);

        // write and IF read together: IF waits for the full write, sees new data
        fork
            mem_access(2'b10, 16'h2222, 16'h1357, lat_a, c1, c2, s_a, rd_a);
            if_access(16'h2222, lat_b, c3, s_b, rd_b);
        join
        chk("t3b_mem_lat", 32'(lat_a), 32'd4);
        chk("t3b_if_lat", 32'(lat_b), 32'd8);
        chk("t3b_if_rdata", 32'(rd_b), 32'h1357);

        // 5. IF request withdrawn right after grant
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0077;
        c1 = 0; c2 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c1 += int'(if_ack);
            c2 += int'(!ram_oe_n);
            if (i == 0) begin @(posedge clk); #1 if_req = 1'b0; end
        end
        chk("t5_acks", 32'(c1), 32'd1);
        chk("t5_oe_cycles", 32'(c2), 32'd2);
        chk("t5_rdata", 32'(if_rdata), 32'h4A36);

        // 4. reset during the write pulse
        @(posedge clk); #1;
        mem_op = 2'b10; mem_addr = 16'h1234; mem_wdata = 16'h5555;
        n = 0;
        @(negedge clk);
        while (ram_we_n && n < 20) begin @(negedge clk); n++; end
        chk("t4_pulse_seen", 32'(n < 20), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t4_we_n", 32'(ram_we_n), 32'd1);
        chk("t4_data_oe", 32'(ram_data_oe), 32'd0);
        chk("t4_en_n", 32'(ram_en_n), 32'd1);
        chk("t4_state", 32'(state_dbg), 32'(ST_IDLE));
        mem_op = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        c1 = 0;
        @(negedge clk);
        chk("t4_state_after", 32'(state_dbg), 32'(ST_IDLE));
        for (int i = 0; i < 4; i++) begin
            c1 += int'(mem_ack);
            @(negedge clk);
        end
        chk("t4_no_ack", 32'(c1), 32'd0);

        // a few more model-checked accesses
        if_access(16'h1000, lat_a, c1, s_a, rd_a);
        chk("t7_if_rdata", 32'(rd_a), 32'h5A41);
        mem_access(2'b01, 16'h2222, 16'h0000, lat_a, c1, c2, s_a, rd_a);
        chk("t7_mem_rdata", 32'(rd_a), 32'h1357);

        // 6. ACCESS_CYCLES=1 build
        @(posedge clk); #1;
        if_req_1 = 1'b1; if_addr_1 = 16'h0010;
        n = 0;
        @(negedge clk);
        while (!if_ack_1 && n < 20) begin @(negedge clk); n++; end
        chk("t6_rd_lat", 32'(n), 32'd2);
        chk("t6_rdata", 32'(if_rdata_1), 32'h1224);
        @(posedge clk); #1 if_req_1 = 1'b0;

        @(posedge clk); #1;
        mem_op_1 = 2'b10; mem_addr_1 = 16'h0020; mem_wdata_1 = 16'hA5A5;
        n = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        @(negedge clk);
        while (1) begin
            c1 += int'(ram_data_oe_1);
            c2 += int'(!ram_we_n_1);
            if (!ram_we_n_1) begin
                c3 += int'(ram_dout_1 == 16'hA5A5);
                c4 += int'(ram_addr_1 == 18'h00020);
            end
            if (mem_ack_1 || n >= 20) break;
            @(negedge clk); n++;
        end
        chk("t6_wr_lat", 32'(n), 32'd3);
        chk("t6_doe_cycles", 32'(c1), 32'd3);
        chk("t6_we_cycles", 32'(c2), 32'd1);
        chk("t6_wdata_ok", 32'(c3), 32'd1);
        chk("t6_waddr_ok", 32'(c4), 32'd1);
        @(posedge clk); #1 mem_op_1 = 2'b11;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
